seven_seg_scan_decoder: RTL

//  Reader side of the four-digit multiplexed seven-segment interface: watches anodes an3..an0
//  and cathodes a..g,dp (all active-low), waits for each scan slot to settle, decodes the pattern

---
 rtl/seven_seg_scan_decoder.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_decoder.sv
// Reads back a 4-digit multiplexed active-low seven-segment bus and publishes whole frames.
// Optional BLANK_DETECT_EN: all-dark segments decode as a legal blank digit with blank_mask output.
module seven_seg_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        an3,
    input  logic        an2,
    input  logic        an1,
    input  logic        an0,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        e,
    input  logic        f,
    input  logic        g,
    input  logic        dp,
    output logic [15:0] digits,
    output logic [3:0]  dp_mask,
    output logic        frame_valid,
    output logic        decode_err,
    output logic        stale
`ifdef BLANK_DETECT_EN
    ,
    output logic [3:0]  blank_mask
`endif
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] SettleMax  = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TimeoutMax = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StCapture, StHold} state_e;

    state_e        state_q, state_d;
    logic [3:0]    an_q, an_d, act_an_q, act_an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_in_q, dp_in_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [15:0]   slots_q, slots_d, digits_q, digits_d;
    logic [3:0]    slot_dp_q, slot_dp_d, mask_q, mask_d, dp_mask_q, dp_mask_d;
    logic          err_q, err_d, frame_valid_q, frame_valid_d;
    logic          decode_err_q, decode_err_d, stale_q, stale_d;
    logic [3:0]    nib;
    logic          seg_ok, an_legal;
    logic [1:0]    cap_idx;
`ifdef BLANK_DETECT_EN
    logic [3:0]    slot_blank_q, slot_blank_d, blank_mask_q, blank_mask_d;
    logic          seg_blank;
`endif

    function automatic logic [1:0] an_index(input logic [3:0] an);
        case (an)
            4'b1101: an_index = 2'd1;
            4'b1011: an_index = 2'd2;
            4'b0111: an_index = 2'd3;
            default: an_index = 2'd0;
        endcase
    endfunction

    assign an_legal = (an_q == 4'b1110) || (an_q == 4'b1101) ||
                      (an_q == 4'b1011) || (an_q == 4'b0111);
    // Slot comes from the latched anode: the live anode may already have moved on in CAPTURE.
    assign cap_idx = an_index(act_an_q);

    always_comb begin
        nib    = 4'h0;
        seg_ok = 1'b1;
`ifdef BLANK_DETECT_EN
        seg_blank = 1'b0;
`endif
        case (seg_q)
            7'b0000001: nib = 4'h0;
            7'b1001111: nib = 4'h1;
            7'b0010010: nib = 4'h2;
            7'b0000110: nib = 4'h3;
            7'b1001100: nib = 4'h4;
            7'b0100100: nib = 4'h5;
            7'b0100000: nib = 4'h6;
            7'b0001111: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0000100: nib = 4'h9;
            7'b0001000: nib = 4'hA;
            7'b1100000: nib = 4'hB;
            7'b0110001: nib = 4'hC;
            7'b1000010: nib = 4'hD;
            7'b0110000: nib = 4'hE;
            7'b0111000: nib = 4'hF;
`ifdef BLANK_DETECT_EN
            7'b1111111: seg_blank = 1'b1;
`endif
            default:    seg_ok = 1'b0;
        endcase
    end

    always_comb begin
        an_d          = {an3, an2, an1, an0};
        seg_d         = {a, b, c, d, e, f, g};
        dp_in_d       = dp;
        state_d       = state_q;
        act_an_d      = act_an_q;
        cnt_d         = cnt_q;
        tcnt_d        = (tcnt_q == TimeoutMax) ? tcnt_q : tcnt_q + TW'(1);
        slots_d       = slots_q;
        slot_dp_d     = slot_dp_q;
        mask_d        = mask_q;
        err_d         = err_q;
        digits_d      = digits_q;
        dp_mask_d     = dp_mask_q;
        decode_err_d  = decode_err_q;
        frame_valid_d = 1'b0;
        stale_d       = stale_q;
`ifdef BLANK_DETECT_EN
        slot_blank_d  = slot_blank_q;
        blank_mask_d  = blank_mask_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (an_legal) begin
                    state_d  = StSettle;
                    act_an_d = an_q;
                    cnt_d    = '0;
                end
            end
            StSettle: begin
                if (an_q != act_an_q)       state_d = StIdle;
                else if (cnt_q == SettleMax) state_d = StCapture;
                else                        cnt_d   = cnt_q + SW'(1);
            end
            StCapture: state_d = StHold;
            StHold:    if (an_q != act_an_q) state_d = StIdle;
            default:   state_d = StIdle;
        endcase

        // Timeout clears first so a capture in the same cycle still lands in the fresh mask.
        if (tcnt_q == TimeoutMax) begin
            stale_d = 1'b1;
            mask_d  = '0;
            err_d   = 1'b0;
        end

        if (state_q == StCapture) begin
            tcnt_d                     = '0;
            slots_d[{cap_idx, 2'b00} +: 4] = nib;
            slot_dp_d[cap_idx]         = ~dp_in_q;
            mask_d[cap_idx]            = 1'b1;
            if (!seg_ok) err_d = 1'b1;
`ifdef BLANK_DETECT_EN
            slot_blank_d[cap_idx]      = seg_blank;
`endif
        end

        if (mask_q == 4'hF) begin
            digits_d      = slots_q;
            dp_mask_d     = slot_dp_q;
            decode_err_d  = err_q;
            frame_valid_d = 1'b1;
            stale_d       = 1'b0;
            mask_d        = '0;
            err_d         = 1'b0;
`ifdef BLANK_DETECT_EN
            blank_mask_d  = slot_blank_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            an_q          <= 4'hF;
            seg_q         <= 7'h7F;
            dp_in_q       <= 1'b1;
            act_an_q      <= 4'hF;
            cnt_q         <= '0;
            tcnt_q        <= '0;
            slots_q       <= '0;
            slot_dp_q     <= '0;
            mask_q        <= '0;
            err_q         <= 1'b0;
            digits_q      <= '0;
            dp_mask_q     <= '0;
            decode_err_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            stale_q       <= 1'b0;
`ifdef BLANK_DETECT_EN
            slot_blank_q  <= '0;
            blank_mask_q  <= '0;
`endif
        end else begin
            state_q       <= state_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_in_q       <= dp_in_d;
            act_an_q      <= act_an_d;
            cnt_q         <= cnt_d;
            tcnt_q        <= tcnt_d;
            slots_q       <= slots_d;
            slot_dp_q     <= slot_dp_d;
            mask_q        <= mask_d;
            err_q         <= err_d;
            digits_q      <= digits_d;
            dp_mask_q     <= dp_mask_d;
            decode_err_q  <= decode_err_d;
            frame_valid_q <= frame_valid_d;
            stale_q       <= stale_d;
`ifdef BLANK_DETECT_EN
            slot_blank_q  <= slot_blank_d;
            blank_mask_q  <= blank_mask_d;
`endif
        end
    end

    assign digits      = digits_q;
    assign dp_mask     = dp_mask_q;
    assign frame_valid = frame_valid_q;
    assign decode_err  = decode_err_q;
    assign stale       = stale_q;
`ifdef BLANK_DETECT_EN
    assign blank_mask  = blank_mask_q;
`endif

endmodule
